// File: rtl/isq_pkg.sv
// Shared defaults, entry layout and width helpers for the issue queue.
package isq_pkg;

  localparam int unsigned ISQ_NUM_ENTRIES = 4;
  localparam int unsigned ISQ_TAG_W       = 6;
  localparam int unsigned ISQ_PAYLOAD_W   = 32;

  typedef struct packed {
    logic                     valid;
    logic [ISQ_PAYLOAD_W-1:0] payload;
    logic [ISQ_TAG_W-1:0]     src1_tag;
    logic [ISQ_TAG_W-1:0]     src2_tag;
    logic                     src1_rdy;
    logic                     src2_rdy;
  } isq_entry_t;

  function automatic int unsigned isq_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned isq_cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/oldest_ready_select.sv
// Age matrix (age_q[i][j]=1: entry i older than j) and oldest-eligible one-hot grant.
module oldest_ready_select
  import isq_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = ISQ_NUM_ENTRIES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] valid,
  input  logic [NUM_ENTRIES-1:0] alloc_oh,
  input  logic [NUM_ENTRIES-1:0] free_oh,
  input  logic [NUM_ENTRIES-1:0] eligible,
  input  logic                   flush,
  output logic [NUM_ENTRIES-1:0] grant_oh
);

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;
  logic [NUM_ENTRIES-1:0]                  blocked;

  always_comb begin
    age_d = age_q;
    for (int unsigned n = 0; n < NUM_ENTRIES; n++) begin
      if (alloc_oh[n]) begin
        age_d[n] = '0;
        for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
          if (j != n) age_d[j][n] = valid[j];
        end
      end
    end
    // Frees are applied after allocs so a same-cycle issuer never keeps a
    // stale "older than" bit against the newly allocated entry.
    for (int unsigned n = 0; n < NUM_ENTRIES; n++) begin
      if (free_oh[n]) begin
        age_d[n] = '0;
        for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
          age_d[j][n] = 1'b0;
        end
      end
    end
    if (flush) age_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end

  always_comb begin
    blocked  = '0;
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
        if (eligible[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
      grant_oh[i] = eligible[i] & ~blocked[i];
    end
  end

endmodule

// File: rtl/issue_queue_ctrl.sv
// Issue-queue control: dispatch into lowest free slot, tag wakeup, oldest-ready issue.
// Optional macro ISQ_WAKEUP_BYPASS_EN lets a same-cycle broadcast count as ready for selection.
module issue_queue_ctrl
  import isq_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = ISQ_NUM_ENTRIES,
  parameter int unsigned TAG_W       = ISQ_TAG_W,
  parameter int unsigned PAYLOAD_W   = ISQ_PAYLOAD_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [PAYLOAD_W-1:0]         disp_payload,
  input  logic [TAG_W-1:0]             disp_src1_tag,
  input  logic [TAG_W-1:0]             disp_src2_tag,
  input  logic                         disp_src1_rdy,
  input  logic                         disp_src2_rdy,
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  output logic [$clog2(NUM_ENTRIES)-1:0] issue_idx,
  input  logic                         flush,
  output logic [$clog2(NUM_ENTRIES):0] occupancy
);

  localparam int unsigned IDX_W = isq_idx_w(NUM_ENTRIES);
  localparam int unsigned CNT_W = isq_cnt_w(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] src1_rdy_q, src1_rdy_d;
  logic [NUM_ENTRIES-1:0] src2_rdy_q, src2_rdy_d;
  logic [PAYLOAD_W-1:0]   payload_q  [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   payload_d  [NUM_ENTRIES];
  logic [TAG_W-1:0]       src1_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       src1_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       src2_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       src2_tag_d [NUM_ENTRIES];

  logic [CNT_W-1:0]       occ_cnt;
  logic                   queue_full;
  logic                   disp_fire;
  logic                   issue_fire;
  logic                   found_free;
  logic [NUM_ENTRIES-1:0] free_sel;
  logic [NUM_ENTRIES-1:0] alloc_oh;
  logic [NUM_ENTRIES-1:0] free_oh;
  logic [NUM_ENTRIES-1:0] wb_hit1, wb_hit2;
  logic [NUM_ENTRIES-1:0] eligible;
  logic [NUM_ENTRIES-1:0] grant_oh;
  logic [IDX_W-1:0]       sel_idx;
  logic [PAYLOAD_W-1:0]   sel_payload;
  logic                   disp_wb1, disp_wb2;

  always_comb begin
    occ_cnt = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      occ_cnt = occ_cnt + CNT_W'(valid_q[i]);
    end
  end

  assign queue_full = (occ_cnt == CNT_W'(NUM_ENTRIES));
  assign disp_ready = ~reset & ~flush & ~queue_full;
  assign disp_fire  = disp_valid & disp_ready;
  assign occupancy  = reset ? '0 : occ_cnt;

  always_comb begin
    free_sel   = '0;
    found_free = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!valid_q[i] && !found_free) begin
        free_sel[i] = 1'b1;
        found_free  = 1'b1;
      end
    end
  end

  assign alloc_oh = disp_fire ? free_sel : '0;

  always_comb begin
    wb_hit1 = '0;
    wb_hit2 = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      wb_hit1[i] = wb_valid && (wb_tag == src1_tag_q[i]);
      wb_hit2[i] = wb_valid && (wb_tag == src2_tag_q[i]);
    end
  end

`ifdef ISQ_WAKEUP_BYPASS_EN
  assign eligible = valid_q & (src1_rdy_q | wb_hit1) & (src2_rdy_q | wb_hit2);
`else
  assign eligible = valid_q & src1_rdy_q & src2_rdy_q;
`endif

  oldest_ready_select #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_select (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid_q),
    .alloc_oh (alloc_oh),
    .free_oh  (free_oh),
    .eligible (eligible),
    .flush    (flush),
    .grant_oh (grant_oh)
  );

  assign issue_valid = ~reset & ~flush & (|grant_oh);
  assign issue_fire  = issue_valid & issue_ready;
  assign free_oh     = issue_fire ? grant_oh : '0;

  always_comb begin
    sel_idx     = '0;
    sel_payload = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (grant_oh[i]) begin
        sel_idx     = sel_idx | IDX_W'(i);
        sel_payload = sel_payload | payload_q[i];
      end
    end
  end

  assign issue_idx     = issue_valid ? sel_idx : '0;
  assign issue_payload = issue_valid ? sel_payload : '0;

  assign disp_wb1 = wb_valid && (wb_tag == disp_src1_tag);
  assign disp_wb2 = wb_valid && (wb_tag == disp_src2_tag);

  always_comb begin
    valid_d    = valid_q;
    src1_rdy_d = src1_rdy_q | (valid_q & wb_hit1);
    src2_rdy_d = src2_rdy_q | (valid_q & wb_hit2);
    payload_d  = payload_q;
    src1_tag_d = src1_tag_q;
    src2_tag_d = src2_tag_q;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (free_oh[i]) valid_d[i] = 1'b0;
      if (alloc_oh[i]) begin
        valid_d[i]    = 1'b1;
        payload_d[i]  = disp_payload;
        src1_tag_d[i] = disp_src1_tag;
        src2_tag_d[i] = disp_src2_tag;
        src1_rdy_d[i] = disp_src1_rdy | disp_wb1;
        src2_rdy_d[i] = disp_src2_rdy | disp_wb2;
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    src1_rdy_q <= src1_rdy_d;
    src2_rdy_q <= src2_rdy_d;
    payload_q  <= payload_d;
    src1_tag_q <= src1_tag_d;
    src2_tag_q <= src2_tag_d;
  end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Directed self-checking bench for issue_queue_ctrl (4 entries, 6-bit tags, 32-bit payload).
module tb_issue_queue_ctrl;
  import isq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid;
  logic        disp_ready;
  logic [31:0] disp_payload;
  logic [5:0]  disp_src1_tag, disp_src2_tag;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_payload;
  logic [1:0]  issue_idx;
  logic        flush;
  logic [2:0]  occupancy;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  issue_queue_ctrl #(
    .NUM_ENTRIES(4),
    .TAG_W      (6),
    .PAYLOAD_W  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_payload (disp_payload),
    .disp_src1_tag(disp_src1_tag),
    .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_rdy(disp_src2_rdy),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_payload(issue_payload),
    .issue_idx    (issue_idx),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_issue(input string tag, input logic v, input logic [1:0] idx,
                             input logic [31:0] pay);
    check({tag, ".valid"},   64'(issue_valid),   64'(v));
    check({tag, ".idx"},     64'(issue_idx),     64'(idx));
    check({tag, ".payload"}, 64'(issue_payload), 64'(pay));
  endtask

  function automatic isq_entry_t mk(input logic [31:0] pay, input logic [5:0] t1,
                                    input logic r1, input logic [5:0] t2, input logic r2);
    isq_entry_t e;
    e.valid    = 1'b1;
    e.payload  = pay;
    e.src1_tag = t1;
    e.src1_rdy = r1;
    e.src2_tag = t2;
    e.src2_rdy = r2;
    return e;
  endfunction

  task automatic idle();
    disp_valid    = 1'b0;
    disp_payload  = '0;
    disp_src1_tag = '0;
    disp_src2_tag = '0;
    disp_src1_rdy = 1'b0;
    disp_src2_rdy = 1'b0;
    wb_valid      = 1'b0;
    wb_tag        = 6'd63;
    issue_ready   = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic disp(input isq_entry_t e);
    disp_valid    = 1'b1;
    disp_payload  = e.payload;
    disp_src1_tag = e.src1_tag;
    disp_src2_tag = e.src2_tag;
    disp_src1_rdy = e.src1_rdy;
    disp_src2_rdy = e.src2_rdy;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".occ"},  64'(occupancy),   64'd0);
    check({tag, ".ivld"}, 64'(issue_valid), 64'd0);
  endtask

  logic [1:0]  drain_idx [4];
  logic [31:0] drain_pay [4];

  initial begin
    reset = 1'b1;
    idle();
    #2;
    check("rst.disp_ready", 64'(disp_ready), 64'd0);
    check_issue("rst", 1'b0, 2'd0, 32'h0);
    check("rst.occ", 64'(occupancy), 64'd0);
    step();
    step();
    reset = 1'b0;
    settle();
    check("post_rst.disp_ready", 64'(disp_ready), 64'd1);
    check_empty("post_rst");

    // In-order issue of three ready micro-ops
    idle(); issue_ready = 1'b1; disp(mk(32'hA, 6'd1, 1'b1, 6'd2, 1'b1)); settle();
    check_issue("s1c1", 1'b0, 2'd0, 32'h0);
    step();
    idle(); issue_ready = 1'b1; disp(mk(32'hB, 6'd1, 1'b1, 6'd2, 1'b1)); settle();
    check_issue("s1c2", 1'b1, 2'd0, 32'hA);
    step();
    idle(); issue_ready = 1'b1; disp(mk(32'hC, 6'd1, 1'b1, 6'd2, 1'b1)); settle();
    check_issue("s1c3", 1'b1, 2'd1, 32'hB);
    step();
    idle(); issue_ready = 1'b1; settle();
    check_issue("s1c4", 1'b1, 2'd0, 32'hC);
    step();
    idle(); settle();
    check_empty("s1end");

    // Wakeup ordering: A waits on tag 5, B ready
    idle(); issue_ready = 1'b1; disp(mk(32'h1A, 6'd5, 1'b0, 6'd3, 1'b1)); settle();
    check("s2c1.ivld", 64'(issue_valid), 64'd0);
    step();
    idle(); issue_ready = 1'b1; disp(mk(32'h1B, 6'd1, 1'b1, 6'd2, 1'b1)); settle();
    check("s2c2.ivld", 64'(issue_valid), 64'd0);
    step();
    idle(); issue_ready = 1'b1; wb_valid = 1'b1; wb_tag = 6'd5; settle();
`ifdef ISQ_WAKEUP_BYPASS_EN
    check_issue("s2c3", 1'b1, 2'd0, 32'h1A);
`else
    check_issue("s2c3", 1'b1, 2'd1, 32'h1B);
`endif
    step();
    idle(); issue_ready = 1'b1; settle();
`ifdef ISQ_WAKEUP_BYPASS_EN
    check_issue("s2c4", 1'b1, 2'd1, 32'h1B);
`else
    check_issue("s2c4", 1'b1, 2'd0, 32'h1A);
`endif
    step();
    idle(); settle();
    check_empty("s2end");

    // Fill, full back-pressure, reuse of the freed slot
    for (int k = 0; k < 4; k++) begin
      idle(); disp(mk(32'h100 + 32'(k), 6'd1, 1'b1, 6'd2, 1'b1)); settle();
      step();
    end
    idle(); disp(mk(32'hDEAD, 6'd1, 1'b1, 6'd2, 1'b1)); settle();
    check("s3full.disp_ready", 64'(disp_ready), 64'd0);
    check("s3full.occ", 64'(occupancy), 64'd4);
    check_issue("s3full", 1'b1, 2'd0, 32'h100);
    step();
    idle(); issue_ready = 1'b1; settle();
    check_issue("s3pop", 1'b1, 2'd0, 32'h100);
    step();
    idle(); disp(mk(32'h104, 6'd1, 1'b1, 6'd2, 1'b1)); settle();
    check("s3reopen.disp_ready", 64'(disp_ready), 64'd1);
    check("s3reopen.occ", 64'(occupancy), 64'd3);
    check_issue("s3reopen", 1'b1, 2'd1, 32'h101);
    step();
    idle(); settle();
    check("s3refill.occ", 64'(occupancy), 64'd4);
    check("s3refill.disp_ready", 64'(disp_ready), 64'd0);
    drain_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
    drain_pay = '{32'h101, 32'h102, 32'h103, 32'h104};
    for (int k = 0; k < 4; k++) begin
      idle(); issue_ready = 1'b1; settle();
      check_issue($sformatf("s3drain%0d", k), 1'b1, drain_idx[k], drain_pay[k]);
      step();
    end
    idle(); settle();
    check_empty("s3end");

    // Hold under back-pressure; older entry waking steals the selection
    idle(); disp(mk(32'h200, 6'd12, 1'b0, 6'd2, 1'b1)); settle(); step();
    idle(); disp(mk(32'h201, 6'd1, 1'b1, 6'd2, 1'b1)); settle(); step();
    idle(); disp(mk(32'h202, 6'd1, 1'b1, 6'd2, 1'b1)); settle(); step();
    for (int k = 0; k < 3; k++) begin
      idle(); settle();
      check_issue($sformatf("s4hold%0d", k), 1'b1, 2'd1, 32'h201);
      step();
    end
    idle(); wb_valid = 1'b1; wb_tag = 6'd12; settle();
`ifdef ISQ_WAKEUP_BYPASS_EN
    check_issue("s4wake", 1'b1, 2'd0, 32'h200);
`else
    check_issue("s4wake", 1'b1, 2'd1, 32'h201);
`endif
    step();
    idle(); settle();
    check_issue("s4older", 1'b1, 2'd0, 32'h200);
    step();
    for (int k = 0; k < 3; k++) begin
      idle(); issue_ready = 1'b1; settle();
      check_issue($sformatf("s4drain%0d", k), 1'b1, 2'(k), 32'h200 + 32'(k));
      step();
    end
    idle(); settle();
    check_empty("s4end");

    // Flush with three entries plus a dispatch in the same cycle
    for (int k = 0; k < 3; k++) begin
      idle(); disp(mk(32'h300 + 32'(k), 6'd1, 1'b1, 6'd2, 1'b1)); settle(); step();
    end
    idle(); flush = 1'b1; issue_ready = 1'b1; disp(mk(32'h3FF, 6'd1, 1'b1, 6'd2, 1'b1)); settle();
    check("s5flush.disp_ready", 64'(disp_ready), 64'd0);
    check("s5flush.ivld", 64'(issue_valid), 64'd0);
    step();
    idle(); settle();
    check_empty("s5after");
    check("s5after.disp_ready", 64'(disp_ready), 64'd1);
    step();
    idle(); settle();
    check("s5later.occ", 64'(occupancy), 64'd0);

    // Wakeup coincident with dispatch
    idle(); disp(mk(32'h400, 6'd9, 1'b0, 6'd4, 1'b1)); wb_valid = 1'b1; wb_tag = 6'd9; settle();
    step();
    idle(); issue_ready = 1'b1; settle();
    check_issue("s6", 1'b1, 2'd0, 32'h400);
    step();
    idle(); settle();
    check_empty("s6end");

    // Non-matching tag must not wake
    idle(); disp(mk(32'h500, 6'd7, 1'b0, 6'd4, 1'b1)); wb_valid = 1'b1; wb_tag = 6'd6; settle();
    step();
    idle(); issue_ready = 1'b1; wb_valid = 1'b1; wb_tag = 6'd8; settle();
    check("s7nowake.ivld", 64'(issue_valid), 64'd0);
    step();

    // Mid-operation reset discards everything
    idle(); disp(mk(32'h600, 6'd1, 1'b1, 6'd2, 1'b1)); settle(); step();
    reset = 1'b1; idle(); settle();
    check("s8rst.occ", 64'(occupancy), 64'd0);
    check("s8rst.disp_ready", 64'(disp_ready), 64'd0);
    step();
    reset = 1'b0; idle(); settle();
    check_empty("s8after");
    check("s8after.disp_ready", 64'(disp_ready), 64'd1);
    idle(); disp(mk(32'h601, 6'd1, 1'b1, 6'd2, 1'b1)); settle(); step();
    idle(); issue_ready = 1'b1; settle();
    check_issue("s8new", 1'b1, 2'd0, 32'h601);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
